// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with multi-lane dispatch, completion and retire.
// Defining ROB_PERF_CNT_EN adds retired-instruction and allocation-stall counters.
module reorder_buffer #(
    parameter int ROB_ENTRIES = 32,
    parameter int DISP_WIDTH  = 2,
    parameter int RET_WIDTH   = 2,
    parameter int NUM_FUS     = 4,
    parameter int AREG_W      = 5,
    parameter int PREG_W      = 6,
    parameter int PC_W        = 32,
    parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DISP_WIDTH-1:0]             alloc_valid,
    input  logic [DISP_WIDTH*AREG_W-1:0]      alloc_dst_areg,
    input  logic [DISP_WIDTH*PREG_W-1:0]      alloc_dst_preg,
    input  logic [DISP_WIDTH*PREG_W-1:0]      alloc_old_preg,
    input  logic [DISP_WIDTH*PC_W-1:0]        alloc_pc,
    output logic                              alloc_ready,
    output logic [DISP_WIDTH*IDX_W-1:0]       alloc_idx,
    input  logic [NUM_FUS-1:0]                cmpl_valid,
    input  logic [NUM_FUS*IDX_W-1:0]          cmpl_idx,
    input  logic [NUM_FUS-1:0]                cmpl_exc,
    output logic [RET_WIDTH-1:0]              ret_valid,
    output logic [RET_WIDTH*AREG_W-1:0]       ret_dst_areg,
    output logic [RET_WIDTH*PREG_W-1:0]       ret_dst_preg,
    output logic [RET_WIDTH*PREG_W-1:0]       ret_old_preg,
    output logic [RET_WIDTH*PC_W-1:0]         ret_pc,
    output logic                              flush_valid,
    output logic [PC_W-1:0]                   flush_pc,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]                       perf_retired,
    output logic [31:0]                       perf_full_cycles,
`endif
    output logic [$clog2(ROB_ENTRIES+1)-1:0]  rob_count
);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(ROB_ENTRIES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       head, tail, count, n_alloc, n_ret;
    logic [ROB_ENTRIES-1:0] ent_valid, ent_done, ent_exc;
    logic [ROB_ENTRIES-1:0] alloc_set, ret_clr, done_set, exc_set;
    logic [AREG_W-1:0]      ent_areg [ROB_ENTRIES];
    logic [PREG_W-1:0]      ent_preg [ROB_ENTRIES];
    logic [PREG_W-1:0]      ent_old  [ROB_ENTRIES];
    logic [PC_W-1:0]        ent_pc   [ROB_ENTRIES];
    logic [DISP_WIDTH-1:0]  acc;
    logic [IDX_W-1:0]       head_idx, cmp_i;
    logic [IDX_W-1:0]       ret_idx [RET_WIDTH];
    logic                   run_a, run_r;

    assign head_idx    = head[IDX_W-1:0];
    assign count       = tail - head;
    assign rob_count   = CNT_W'(count);
    assign alloc_ready = (state == RUN) && (int'(count) <= ROB_ENTRIES - DISP_WIDTH);
    assign flush_valid = (state == RUN) && ent_valid[head_idx] && ent_done[head_idx] && ent_exc[head_idx];
    assign flush_pc    = flush_valid ? ent_pc[head_idx] : '0;

    // Only the leading run of valid lanes is accepted.
    always_comb begin
        run_a     = alloc_ready;
        n_alloc   = '0;
        alloc_set = '0;
        acc       = '0;
        alloc_idx = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            alloc_idx[k*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(k);
            run_a = run_a && alloc_valid[k];
            acc[k] = run_a;
            if (run_a) alloc_set[alloc_idx[k*IDX_W +: IDX_W]] = 1'b1;
            n_alloc = n_alloc + PTR_W'(run_a);
        end
    end

    always_comb begin
        run_r        = state == RUN;
        n_ret        = '0;
        ret_clr      = '0;
        ret_valid    = '0;
        ret_dst_areg = '0;
        ret_dst_preg = '0;
        ret_old_preg = '0;
        ret_pc       = '0;
        for (int r = 0; r < RET_WIDTH; r++) begin
            ret_idx[r] = head_idx + IDX_W'(r);
            run_r = run_r && ent_valid[ret_idx[r]] && ent_done[ret_idx[r]] && !ent_exc[ret_idx[r]];
            ret_valid[r] = run_r;
            if (run_r) ret_clr[ret_idx[r]] = 1'b1;
            n_ret = n_ret + PTR_W'(run_r);
            ret_dst_areg[r*AREG_W +: AREG_W] = ent_areg[ret_idx[r]];
            ret_dst_preg[r*PREG_W +: PREG_W] = ent_preg[ret_idx[r]];
            ret_old_preg[r*PREG_W +: PREG_W] = ent_old[ret_idx[r]];
            ret_pc[r*PC_W +: PC_W]           = ent_pc[ret_idx[r]];
        end
    end

    // Ports hitting the same entry accumulate their exception bits.
    always_comb begin
        done_set = '0;
        exc_set  = '0;
        cmp_i    = '0;
        for (int c = 0; c < NUM_FUS; c++) begin
            cmp_i = cmpl_idx[c*IDX_W +: IDX_W];
            if (cmpl_valid[c] && ent_valid[cmp_i]) begin
                done_set[cmp_i] = 1'b1;
                exc_set[cmp_i]  = exc_set[cmp_i] | cmpl_exc[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_exc   <= '0;
        end else if (state == FLUSH) begin
            state <= RUN;
        end else if (flush_valid) begin
            state     <= FLUSH;
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
        end else begin
            head      <= head + n_ret;
            tail      <= tail + n_alloc;
            ent_valid <= (ent_valid & ~ret_clr) | alloc_set;
            ent_done  <= (ent_done | done_set) & ~alloc_set;
            ent_exc   <= (ent_exc | exc_set) & ~alloc_set;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (acc[k]) begin
                ent_areg[alloc_idx[k*IDX_W +: IDX_W]] <= alloc_dst_areg[k*AREG_W +: AREG_W];
                ent_preg[alloc_idx[k*IDX_W +: IDX_W]] <= alloc_dst_preg[k*PREG_W +: PREG_W];
                ent_old[alloc_idx[k*IDX_W +: IDX_W]]  <= alloc_old_preg[k*PREG_W +: PREG_W];
                ent_pc[alloc_idx[k*IDX_W +: IDX_W]]   <= alloc_pc[k*PC_W +: PC_W];
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired     <= '0;
            perf_full_cycles <= '0;
        end else begin
            perf_retired     <= perf_retired + 32'(n_ret);
            perf_full_cycles <= perf_full_cycles + 32'(state == RUN && !alloc_ready);
        end
    end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random checks of reorder_buffer against a queue-based ROB model.
module tb_reorder_buffer;
    logic        clk = 0;
    logic        rst;
    logic [1:0]  alloc_valid;
    logic [9:0]  alloc_dst_areg;
    logic [11:0] alloc_dst_preg, alloc_old_preg;
    logic [63:0] alloc_pc;
    logic        alloc_ready;
    logic [9:0]  alloc_idx;
    logic [3:0]  cmpl_valid, cmpl_exc;
    logic [19:0] cmpl_idx;
    logic [1:0]  ret_valid;
    logic [9:0]  ret_dst_areg;
    logic [11:0] ret_dst_preg, ret_old_preg;
    logic [63:0] ret_pc;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [5:0]  rob_count;

    int total = 0, bad = 0;
    bit go = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_dst_areg(alloc_dst_areg), .alloc_dst_preg(alloc_dst_preg),
        .alloc_old_preg(alloc_old_preg), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_exc(cmpl_exc),
        .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg), .ret_dst_preg(ret_dst_preg),
        .ret_old_preg(ret_old_preg), .ret_pc(ret_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  idx;
        logic [4:0]  areg;
        logic [5:0]  preg;
        logic [5:0]  old;
        logic [31:0] pc;
        logic        done;
        logic        exc;
    } ent_t;

    ent_t q[$];
    int   tail_pos = 0;
    bit   in_flush = 0;
    bit   m_rdy, m_ok;
    int   m_nr;
    ent_t m_e;
    int   c_nr;
    bit   c_fl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !in_flush && (32 - q.size() >= 2);
    endfunction

    function automatic int m_retires();
        int n = 0;
        while (!in_flush && n < 2 && n < q.size() && q[n].done && !q[n].exc) n++;
        return n;
    endfunction

    function automatic bit m_flush();
        return !in_flush && q.size() > 0 && q[0].done && q[0].exc;
    endfunction

    // Program-order queue model of the ROB.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            tail_pos = 0;
            in_flush = 0;
        end else if (in_flush) begin
            in_flush = 0;
        end else if (m_flush()) begin
            q.delete();
            tail_pos = 0;
            in_flush = 1;
        end else begin
            m_rdy = m_ready();
            m_nr  = m_retires();
            for (int c = 0; c < 4; c++)
                if (cmpl_valid[c])
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].idx == cmpl_idx[c*5 +: 5]) begin
                            m_e = q[i];
                            m_e.done = 1'b1;
                            m_e.exc = m_e.exc | cmpl_exc[c];
                            q[i] = m_e;
                        end
            for (int i = 0; i < m_nr; i++) void'(q.pop_front());
            m_ok = m_rdy;
            for (int k = 0; k < 2; k++) begin
                m_ok = m_ok && alloc_valid[k];
                if (m_ok) begin
                    m_e.idx  = 5'(tail_pos);
                    m_e.areg = alloc_dst_areg[k*5 +: 5];
                    m_e.preg = alloc_dst_preg[k*6 +: 6];
                    m_e.old  = alloc_old_preg[k*6 +: 6];
                    m_e.pc   = alloc_pc[k*32 +: 32];
                    m_e.done = 1'b0;
                    m_e.exc  = 1'b0;
                    q.push_back(m_e);
                    tail_pos = (tail_pos + 1) % 32;
                end
            end
        end
    end

    always @(negedge clk) if (go) begin
        c_nr = m_retires();
        c_fl = m_flush();
        chk("rob_count", 64'(rob_count), 64'(q.size()));
        chk("alloc_ready", 64'(alloc_ready), 64'(m_ready()));
        for (int k = 0; k < 2; k++) chk("alloc_idx", 64'(alloc_idx[k*5 +: 5]), 64'((tail_pos + k) % 32));
        chk("ret_valid", 64'(ret_valid), 64'(c_nr == 2 ? 2'b11 : c_nr == 1 ? 2'b01 : 2'b00));
        for (int r = 0; r < c_nr; r++) begin
            chk("ret_pc", 64'(ret_pc[r*32 +: 32]), 64'(q[r].pc));
            chk("ret_old_preg", 64'(ret_old_preg[r*6 +: 6]), 64'(q[r].old));
            chk("ret_dst_preg", 64'(ret_dst_preg[r*6 +: 6]), 64'(q[r].preg));
            chk("ret_dst_areg", 64'(ret_dst_areg[r*5 +: 5]), 64'(q[r].areg));
        end
        chk("flush_valid", 64'(flush_valid), 64'(c_fl));
        if (c_fl) chk("flush_pc", 64'(flush_pc), 64'(q[0].pc));
        else chk("flush_pc", 64'(flush_pc), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_valid = '0; alloc_dst_areg = '0; alloc_dst_preg = '0; alloc_old_preg = '0; alloc_pc = '0;
        cmpl_valid = '0; cmpl_idx = '0; cmpl_exc = '0;
    endtask

    task automatic alloc2(input int base);
        alloc_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            alloc_dst_areg[k*5 +: 5]  = 5'(base + k);
            alloc_dst_preg[k*6 +: 6]  = 6'(base + k + 32);
            alloc_old_preg[k*6 +: 6]  = 6'(base + k);
            alloc_pc[k*32 +: 32]      = 32'h100 + 32'(4 * (base + k));
        end
    endtask

    task automatic cmpl(input int p, input int idx, input logic exc);
        cmpl_valid[p]      = 1'b1;
        cmpl_idx[p*5 +: 5] = 5'(idx);
        cmpl_exc[p]        = exc;
    endtask

    task automatic do_reset();
        clr();
        rst = 0;
        #2;
        rst = 1;
        tick();
    endtask

    int pr;
    int v;

    initial begin
        rst = 1;
        clr();
        #3 rst = 0;
        go = 1;
        #10;
        chk("rst_count", 64'(rob_count), 64'(0));
        chk("rst_ready", 64'(alloc_ready), 64'(1));
        chk("rst_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
        chk("rst_ret", 64'(ret_valid), 64'(0));
        chk("rst_flush", 64'(flush_valid), 64'(0));
        chk("rst_flush_pc", 64'(flush_pc), 64'(0));
        @(posedge clk); #1;
        rst = 1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_idx0", 64'(alloc_idx[4:0]), 64'(2 * i));
            chk("fill_idx1", 64'(alloc_idx[9:5]), 64'(2 * i + 1));
            if (i == 15) begin
                chk("fill_count30", 64'(rob_count), 64'(30));
                chk("fill_ready30", 64'(alloc_ready), 64'(1));
            end
            alloc2(2 * i);
            tick();
        end
        clr();
        chk("full_count", 64'(rob_count), 64'(32));
        chk("full_ready", 64'(alloc_ready), 64'(0));
        tick();
        chk("full_ret", 64'(ret_valid), 64'(0));
        do_reset();
        alloc2(0); tick();
        alloc2(2); tick();
        clr();
        cmpl(0, 3, 0); cmpl(1, 2, 0); cmpl(2, 1, 0);
        tick(); clr();
        chk("ooo_hold", 64'(ret_valid), 64'(0));
        chk("ooo_count", 64'(rob_count), 64'(4));
        cmpl(0, 0, 0);
        tick(); clr();
        chk("ooo_ret01", 64'(ret_valid), 64'(2'b11));
        chk("ooo_pc0", 64'(ret_pc[31:0]), 64'(32'h100));
        chk("ooo_pc1", 64'(ret_pc[63:32]), 64'(32'h104));
        chk("ooo_old1", 64'(ret_old_preg[11:6]), 64'(1));
        tick();
        chk("ooo_ret23", 64'(ret_valid), 64'(2'b11));
        chk("ooo_pc2", 64'(ret_pc[31:0]), 64'(32'h108));
        chk("ooo_pc3", 64'(ret_pc[63:32]), 64'(32'h10C));
        chk("ooo_count2", 64'(rob_count), 64'(2));
        tick();
        chk("ooo_empty", 64'(rob_count), 64'(0));
        alloc2(4); tick(); clr();
        cmpl(0, 4, 0); tick(); clr();
        chk("pre_rst_ret", 64'(ret_valid), 64'(2'b01));
        rst = 0;
        #1;
        chk("arst_ret", 64'(ret_valid), 64'(0));
        chk("arst_flush", 64'(flush_valid), 64'(0));
        chk("arst_count", 64'(rob_count), 64'(0));
        chk("arst_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
        #1 rst = 1;
        tick();
        alloc2(0); tick();
        alloc2(2); tick();
        clr();
        cmpl(0, 0, 0); cmpl(1, 1, 0); cmpl(2, 2, 1); cmpl(3, 3, 0);
        tick(); clr();
        chk("exc_ret01", 64'(ret_valid), 64'(2'b11));
        chk("exc_noflush", 64'(flush_valid), 64'(0));
        tick();
        chk("exc_flush", 64'(flush_valid), 64'(1));
        chk("exc_flush_pc", 64'(flush_pc), 64'(32'h108));
        chk("exc_noret", 64'(ret_valid), 64'(0));
        tick();
        chk("flush_ready", 64'(alloc_ready), 64'(0));
        chk("flush_pulse", 64'(flush_valid), 64'(0));
        chk("flush_count", 64'(rob_count), 64'(0));
        tick();
        chk("post_ready", 64'(alloc_ready), 64'(1));
        chk("post_idx", 64'(alloc_idx), 64'({5'd1, 5'd0}));
        for (int i = 0; i < 5; i++) begin alloc2(2 * i); tick(); end
        clr();
        cmpl(0, 0, 0); cmpl(1, 1, 0);
        tick(); clr();
        chk("sim_count", 64'(rob_count), 64'(10));
        chk("sim_ret", 64'(ret_valid), 64'(2'b11));
        alloc2(10); cmpl(0, 0, 0);
        tick(); clr();
        chk("sim_count_same", 64'(rob_count), 64'(10));
        cmpl(0, 0, 0);
        tick(); clr();
        chk("freed_cmpl_ret", 64'(ret_valid), 64'(0));
        chk("freed_cmpl_count", 64'(rob_count), 64'(10));
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            v = $urandom_range(0, 5);
            alloc_valid = v == 0 ? 2'b00 : v == 1 ? 2'b01 : 2'b11;
            alloc_dst_areg = 10'($urandom());
            alloc_dst_preg = 12'($urandom());
            alloc_old_preg = 12'($urandom());
            alloc_pc = {$urandom(), $urandom()};
            pr = (n % 1000 < 500) ? 3 : 1;
            for (int c = 0; c < 4; c++) begin
                cmpl_valid[c] = ($urandom_range(0, pr) == 0);
                if (q.size() > 0 && $urandom_range(0, 9) != 0)
                    cmpl_idx[c*5 +: 5] = q[$urandom_range(0, q.size() - 1)].idx;
                else
                    cmpl_idx[c*5 +: 5] = 5'($urandom_range(0, 31));
                cmpl_exc[c] = ($urandom_range(0, 199) == 0);
            end
            tick();
        end
        clr();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
